ir_frame_parser: RTL and testbench
==================================

// Module: ir_frame_parser
// PURPOSE
// - Consumer stage for the 32-bit IR decoder; takes its code/new_code pulse pair.
// - Splits each frame into address/command and checks the NEC complement bytes.
// - Tags a frame as a key-held repeat when the same code arrives inside HOLD_WINDOW.
// - Buffers accepted frames in a small FIFO with a valid/ready output toward app logic.
// PARAMETERS
// - EXT_ADDR        0           1: address is 16 bit, no address-complement check.
// - HOLD_WINDOW     11_000_000  cycles (110 ms @100MHz) for same-code repeat detection.
// - SUPPRESS_REPEAT 0           1: drop repeat-tagged frames instead of queueing them.
// - DEPTH           4           FIFO entries; power of 2, >=2.
// PORTS
// - clk_in        in   1   system clock, 100 MHz
// - rst_in        in   1   synchronous, active-high reset
// - code_in       in   32  frame from the decoder; first byte received in [31:24]
// - new_code_in   in   1   1-cycle strobe; code_in is valid this cycle
// - addr_out      out  16  head entry address (EXT_ADDR=0: {8'h00,code[31:24]})
// - cmd_out       out  8   head entry command, code[15:8]
// - repeat_out    out  1   head entry was a hold-window repeat
// - valid_out     out  1   FIFO non-empty; head fields valid
// - ready_in      in   1   consumer pop; entry leaves on valid_out&&ready_in
// - err_out       out  2   1-cycle: [0] address-complement fail, [1] command-complement fail
// - overflow_out  out  1   1-cycle: valid frame dropped because FIFO full
// BEHAVIOUR
// - Reset: FIFO empty; all outputs 0; tracker IDLE; last_code=0; timer=0.
// - Stage 0 (cycle N, new_code_in=1): register code_in, decoded fields, check result.
// - Checks: addr_ok = EXT_ADDR || code[23:16]==~code[31:24]; cmd_ok = code[7:0]==~code[15:8].
// - Stage 1 (cycle N+1): on any check fail, pulse err_out={!cmd_ok,!addr_ok}.
//   - Failed frame: no push; tracker/timer unchanged.
// - Stage 1 accepted frame: rpt = (tracker==HELD && code==last_code).
// - Stage 1 accepted frame: last_code<=code; timer<=0; tracker<=HELD.
// - Stage 1 push: push unless (SUPPRESS_REPEAT && rpt).
//   - Pushed entry data: {addr,cmd,rpt}.
//   - Earliest valid_out: cycle N+2.
// - Tracker FSM: IDLE -> HELD on accepted frame.
//   - HELD: timer increments each cycle; restarts at 0 on each accepted frame.
//   - HELD -> IDLE when timer reaches HOLD_WINDOW-1.
//   - Timer is wide enough for HOLD_WINDOW and never wraps.
// - Different valid code inside window: rpt=0, becomes new last_code.
// - FIFO: count 0..DEPTH; pointers wrap modulo DEPTH.
//   - Full + push + pop same cycle: both happen; count stays DEPTH; no overflow.
//   - Full + push, no pop: frame dropped, overflow_out pulses; tracker still updates.
// - Empty: valid_out=0; ready_in ignored; head outputs hold last value.
// - new_code_in back-to-back every cycle: every frame is processed; no frame is lost except on overflow.
// - Reset mid-operation: pipeline, FIFO and tracker cleared next edge; pending err/overflow pulses cancelled.
// TESTING
// - 0x10EF45BA strobe, ready_in=1:
//   - valid_out at N+2, addr_out=0x0010, cmd_out=0x45, repeat_out=0.
//   - Popped the same cycle.
// - 0x10EE45BA -> err_out=2'b01 at N+1, no valid_out.
// - 0x10EF45BB -> err_out=2'b10.
// - EXT_ADDR=1: 0x12344580 -> addr_out=0x1234 (no addr check), err_out=2'b10.
// - Hold window, HOLD_WINDOW=100, 0x10EF45BA:
//   - Second strobe 50 cycles later -> repeat_out=1.
//   - Third strobe 150 cycles after second -> repeat_out=0.
//   - SUPPRESS_REPEAT=1: only 2 entries queued.
// - ready_in=0, DEPTH=4, 5 valid frames:
//   - Count 4, overflow_out pulses on frame 5.
//   - Then full+push+pop same cycle: no overflow, order preserved.
// - Reset asserted with 3 entries queued -> valid_out=0 next cycle.
//   - Following 0x10EF45BA gives repeat_out=0.

Source files
------------

// File: rtl/ir_frame_parser.sv
// ---------------------------------------------------------------------------
// ir_frame_parser
//   Consumer stage for the 32-bit IR decoder. Each frame is split into
//   address and command fields, and the NEC complement bytes are checked.
//   A frame that repeats the previous code inside HOLD_WINDOW cycles is
//   tagged as a key-held repeat. Accepted frames are queued in a small FIFO
//   that presents a valid/ready interface to the application logic.
//
// Parameters
//   EXT_ADDR        1: 16-bit address, no address-complement check
//   HOLD_WINDOW     repeat-detection window, in clk_in cycles
//   SUPPRESS_REPEAT 1: repeat-tagged frames are dropped, not queued
//   DEPTH           FIFO entries (power of 2, >= 2)
//
// Ports
//   clk_in        in   system clock
//   rst_in        in   synchronous active-high reset
//   code_in       in   [31:0] frame, first received byte in [31:24]
//   new_code_in   in   one-cycle strobe, code_in valid
//   addr_out      out  [15:0] head entry address
//   cmd_out       out  [7:0]  head entry command
//   repeat_out    out  head entry is a hold-window repeat
//   valid_out     out  FIFO non-empty, head fields valid
//   ready_in      in   consumer pop (valid_out && ready_in)
//   err_out       out  [1:0] one-cycle pulse: [0] addr check, [1] cmd check
//   overflow_out  out  one-cycle pulse: accepted frame dropped, FIFO full
// ---------------------------------------------------------------------------
module ir_frame_parser #(
  parameter int EXT_ADDR        = 0,
  parameter int HOLD_WINDOW     = 11_000_000,
  parameter int SUPPRESS_REPEAT = 0,
  parameter int DEPTH           = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        new_code_in,
  output logic [15:0] addr_out,
  output logic [7:0]  cmd_out,
  output logic        repeat_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [1:0]  err_out,
  output logic        overflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(HOLD_WINDOW + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Stage-1 registers: the captured frame and its check results.
  logic        s1_valid;
  logic [31:0] s1_code;
  logic [15:0] s1_addr;
  logic [7:0]  s1_cmd;
  logic        s1_addr_ok;
  logic        s1_cmd_ok;

  // Repeat tracker.
  logic [0:0]    state;
  logic [31:0]   last_code;
  logic [TW-1:0] timer;

  // FIFO storage; entry = {addr, cmd, rpt}.
  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [24:0]   head_q;

  logic s1_accept, s1_rpt, push_req, full, pop, push;
  logic [24:0] head;

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update together from values sampled at the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) s1_valid <= 1'b0;
    else        s1_valid <= new_code_in;
  end

  // Data fields are only consumed when s1_valid is set, so they carry no reset.
  always_ff @(posedge clk_in) begin
    if (new_code_in) begin
      s1_code    <= code_in;
      s1_addr    <= (EXT_ADDR != 0) ? code_in[31:16] : {8'h00, code_in[31:24]};
      s1_cmd     <= code_in[15:8];
      s1_addr_ok <= (EXT_ADDR != 0) || (code_in[23:16] == ~code_in[31:24]);
      s1_cmd_ok  <= (code_in[7:0] == ~code_in[15:8]);
    end
  end

  // NOTE: every output of this always_comb is given a default first, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    s1_accept    = s1_valid && s1_addr_ok && s1_cmd_ok;
    s1_rpt       = (state == ST_HELD) && (s1_code == last_code);
    push_req     = s1_accept && !((SUPPRESS_REPEAT != 0) && s1_rpt);
    full         = (count == CW'(DEPTH));
    valid_out    = (count != '0);
    pop          = valid_out && ready_in;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    push         = push_req && (!full || pop);
    overflow_out = push_req && full && !pop;
    err_out      = s1_valid ? {!s1_cmd_ok, !s1_addr_ok} : 2'b00;
    // When empty, the last popped entry stays on the head outputs.
    head         = valid_out ? mem[rd_ptr] : head_q;
    addr_out     = head[24:9];
    cmd_out      = head[8:1];
    repeat_out   = head[0];
  end

  // Tracker: a dropped-on-overflow frame is still an accepted frame and
  // restarts the hold window; failed frames leave it untouched.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      last_code <= '0;
      timer     <= '0;
    end else if (s1_accept) begin
      state     <= ST_HELD;
      last_code <= s1_code;
      timer     <= '0;
    end else if (state == ST_HELD) begin
      // The timer stops at HOLD_WINDOW-1, so it can never wrap.
      if (timer == TW'(HOLD_WINDOW - 1)) state <= ST_IDLE;
      else                               timer <= timer + TW'(1);
    end
  end

  // NOTE: the FIFO array has no reset; emptiness is tracked by count, and
  // leaving storage unreset lets it map onto plain RAM/register files.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= {s1_addr, s1_cmd, s1_rpt};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        head_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_ir_frame_parser
//   Three instances share clock, reset, code and ready:
//     dut_m : EXT_ADDR=0, HOLD_WINDOW=100, SUPPRESS_REPEAT=0
//     dut_e : EXT_ADDR=1, HOLD_WINDOW=100
//     dut_s : SUPPRESS_REPEAT=1, HOLD_WINDOW=100
//   Each has its own strobe. Expected entries and error codes are queued
//   when stimulus is issued; a monitor pops and compares on every pop or
//   error pulse.
// ---------------------------------------------------------------------------
module tb_ir_frame_parser;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] code   = '0;
  logic        ready  = 1'b0;
  logic        nc_m = 1'b0, nc_e = 1'b0, nc_s = 1'b0;

  logic [15:0] m_addr, e_addr, s_addr;
  logic [7:0]  m_cmd,  e_cmd,  s_cmd;
  logic        m_rpt,  e_rpt,  s_rpt;
  logic        m_valid, e_valid, s_valid;
  logic [1:0]  m_err,  e_err,  s_err;
  logic        m_ovf,  e_ovf,  s_ovf;

  int tests = 0;
  int fails = 0;
  int ovf_seen  = 0;
  int ovf_other = 0;
  int s_pops    = 0;

  logic [24:0] q_m[$];
  logic [24:0] q_e[$];
  logic [24:0] q_s[$];
  logic [1:0]  eq_m[$];
  logic [1:0]  eq_e[$];

  always #5 clk_in = ~clk_in;

  ir_frame_parser #(.EXT_ADDR(0), .HOLD_WINDOW(100), .SUPPRESS_REPEAT(0), .DEPTH(4)) dut_m (
    .clk_in(clk_in), .rst_in(rst_in), .code_in(code), .new_code_in(nc_m),
    .addr_out(m_addr), .cmd_out(m_cmd), .repeat_out(m_rpt), .valid_out(m_valid),
    .ready_in(ready), .err_out(m_err), .overflow_out(m_ovf));

  ir_frame_parser #(.EXT_ADDR(1), .HOLD_WINDOW(100), .SUPPRESS_REPEAT(0), .DEPTH(4)) dut_e (
    .clk_in(clk_in), .rst_in(rst_in), .code_in(code), .new_code_in(nc_e),
    .addr_out(e_addr), .cmd_out(e_cmd), .repeat_out(e_rpt), .valid_out(e_valid),
    .ready_in(ready), .err_out(e_err), .overflow_out(e_ovf));

  ir_frame_parser #(.EXT_ADDR(0), .HOLD_WINDOW(100), .SUPPRESS_REPEAT(1), .DEPTH(4)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in), .code_in(code), .new_code_in(nc_s),
    .addr_out(s_addr), .cmd_out(s_cmd), .repeat_out(s_rpt), .valid_out(s_valid),
    .ready_in(ready), .err_out(s_err), .overflow_out(s_ovf));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h, required nothing", name, act);
  endtask

  function automatic logic [24:0] ent(input logic [15:0] a, input logic [7:0] c, input logic r);
    return {a, c, r};
  endfunction

  // mask bit 0: dut_m, bit 1: dut_e, bit 2: dut_s
  task automatic strobe(input logic [31:0] c, input logic [2:0] mask);
    @(posedge clk_in); #1;
    code = c;
    nc_m = mask[0]; nc_e = mask[1]; nc_s = mask[2];
    @(posedge clk_in); #1;
    nc_m = 1'b0; nc_e = 1'b0; nc_s = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Monitor: compares whatever the DUTs present against the scoreboards.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (m_valid && ready) begin
        if (q_m.size() == 0) unexpected("m_pop", 32'({m_addr, m_cmd, m_rpt}));
        else check("m_pop", 32'({m_addr, m_cmd, m_rpt}), 32'(q_m.pop_front()));
      end
      if (e_valid && ready) begin
        if (q_e.size() == 0) unexpected("e_pop", 32'({e_addr, e_cmd, e_rpt}));
        else check("e_pop", 32'({e_addr, e_cmd, e_rpt}), 32'(q_e.pop_front()));
      end
      if (s_valid && ready) begin
        s_pops++;
        if (q_s.size() == 0) unexpected("s_pop", 32'({s_addr, s_cmd, s_rpt}));
        else check("s_pop", 32'({s_addr, s_cmd, s_rpt}), 32'(q_s.pop_front()));
      end
      if (m_err != 2'b00) begin
        if (eq_m.size() == 0) unexpected("m_err", 32'(m_err));
        else check("m_err", 32'(m_err), 32'(eq_m.pop_front()));
      end
      if (e_err != 2'b00) begin
        if (eq_e.size() == 0) unexpected("e_err", 32'(e_err));
        else check("e_err", 32'(e_err), 32'(eq_e.pop_front()));
      end
      if (s_err != 2'b00) unexpected("s_err", 32'(s_err));
      if (m_ovf) ovf_seen++;
      if (e_ovf || s_ovf) ovf_other++;
    end
  end

  initial begin
    logic [31:0] bcodes [3];
    logic [7:0]  c8;

    // ---- reset state ----
    idle(3);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_err",   32'(m_err), 0);
    check("rst_ovf",   32'(m_ovf), 0);
    check("rst_head",  32'({m_addr, m_cmd, m_rpt}), 0);
    check("rst_valid_e", 32'(e_valid), 0);
    check("rst_valid_s", 32'(s_valid), 0);

    // ---- basic frame, latency N+2, popped immediately ----
    ready = 1'b1;
    q_m.push_back(ent(16'h0010, 8'h45, 1'b0));
    strobe(32'h10EF45BA, 3'b001);
    @(negedge clk_in);
    check("lat_n1_valid", 32'(m_valid), 0);
    check("lat_n1_err",   32'(m_err), 0);
    @(negedge clk_in);
    check("lat_n2_valid", 32'(m_valid), 1);
    @(negedge clk_in);
    check("popped_valid", 32'(m_valid), 0);
    check("empty_hold_addr", 32'(m_addr), 32'h0010);
    check("empty_hold_cmd",  32'(m_cmd),  32'h45);

    // ---- complement failures ----
    eq_m.push_back(2'b01);
    strobe(32'h10EE45BA, 3'b001);
    @(negedge clk_in);
    check("addr_fail_err", 32'(m_err), 32'h1);
    @(negedge clk_in);
    check("addr_fail_novalid", 32'(m_valid), 0);
    eq_m.push_back(2'b10);
    strobe(32'h10EF45BB, 3'b001);
    @(negedge clk_in);
    check("cmd_fail_err", 32'(m_err), 32'h2);
    @(negedge clk_in);
    check("cmd_fail_novalid", 32'(m_valid), 0);

    // ---- hold window (main and suppress instances) ----
    idle(150);
    q_m.push_back(ent(16'h0010, 8'h45, 1'b0));
    q_s.push_back(ent(16'h0010, 8'h45, 1'b0));
    strobe(32'h10EF45BA, 3'b101);
    idle(48);
    q_m.push_back(ent(16'h0010, 8'h45, 1'b1));
    strobe(32'h10EF45BA, 3'b101);
    idle(148);
    q_m.push_back(ent(16'h0010, 8'h45, 1'b0));
    q_s.push_back(ent(16'h0010, 8'h45, 1'b0));
    strobe(32'h10EF45BA, 3'b101);
    idle(4);
    check("sup_entries", 32'(s_pops), 2);

    // Different code inside the window, then back-to-back strobes.
    q_m.push_back(ent(16'h0020, 8'h45, 1'b0));
    strobe(32'h20DF45BA, 3'b001);
    bcodes[0] = 32'h10EF45BA;
    bcodes[1] = 32'h10EF45BA;
    bcodes[2] = 32'h30CF1EE1;
    q_m.push_back(ent(16'h0010, 8'h45, 1'b0));
    q_m.push_back(ent(16'h0010, 8'h45, 1'b1));
    q_m.push_back(ent(16'h0030, 8'h1E, 1'b0));
    @(posedge clk_in); #1;
    for (int i = 0; i < 3; i++) begin
      code = bcodes[i];
      nc_m = 1'b1;
      @(posedge clk_in); #1;
    end
    nc_m = 1'b0;
    idle(5);

    // ---- extended address ----
    q_e.push_back(ent(16'h1234, 8'h45, 1'b0));
    strobe(32'h123445BA, 3'b010);
    eq_e.push_back(2'b10);
    strobe(32'h12344580, 3'b010);
    @(negedge clk_in);
    check("ext_err", 32'(e_err), 32'h2);
    idle(4);

    // ---- overflow: 5 frames into a 4-deep FIFO with no pops ----
    ready = 1'b0;
    @(posedge clk_in); #1;
    for (int i = 0; i < 5; i++) begin
      c8   = 8'(i);
      code = {16'h01FE, c8, ~c8};
      if (i < 4) q_m.push_back(ent(16'h0001, c8, 1'b0));
      nc_m = 1'b1;
      @(posedge clk_in); #1;
    end
    nc_m = 1'b0;
    idle(3);
    check("ovf_count", 32'(ovf_seen), 1);
    check("ovf_full_valid", 32'(m_valid), 1);

    // Full + push + pop in the same cycle. The frame repeats the dropped
    // frame 5, which still updated the tracker, so it is a repeat.
    q_m.push_back(ent(16'h0001, 8'h04, 1'b1));
    strobe(32'h01FE04FB, 3'b001);
    ready = 1'b1;
    idle(8);
    check("ovf_no_extra", 32'(ovf_seen), 1);
    check("drain_valid", 32'(m_valid), 0);

    // ---- reset with 3 entries queued and an error frame in flight ----
    ready = 1'b0;
    strobe(32'h01FE00FF, 3'b001);
    strobe(32'h01FE01FE, 3'b001);
    strobe(32'h10EF45BA, 3'b001);
    idle(2);
    check("pre_rst_valid", 32'(m_valid), 1);
    @(posedge clk_in); #1;
    code   = 32'h10EE45BA;
    nc_m   = 1'b1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    nc_m   = 1'b0;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_mid_valid", 32'(m_valid), 0);
    check("rst_mid_err",   32'(m_err), 0);
    check("rst_mid_head",  32'({m_addr, m_cmd, m_rpt}), 0);
    ready = 1'b1;
    q_m.push_back(ent(16'h0010, 8'h45, 1'b0));
    strobe(32'h10EF45BA, 3'b001);
    idle(4);

    // ---- leftovers ----
    check("q_m_empty",  32'(q_m.size()), 0);
    check("q_e_empty",  32'(q_e.size()), 0);
    check("q_s_empty",  32'(q_s.size()), 0);
    check("eq_m_empty", 32'(eq_m.size()), 0);
    check("eq_e_empty", 32'(eq_e.size()), 0);
    check("ovf_other",  32'(ovf_other), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
